psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream consumer of the combinational `sum` stage, which reduces 4 packed 3-bit lanes to one 3-bit partial sum per cycle.
- Accumulates a stream of these partial sums over a fixed number of beats, or until an early `in_last`, into one wide result.
- Presents each result on a valid/ready output to the systolic array's result collection logic.
- Sustains one input beat per clock.

Parameters:
- IN_W, 3, width of each unsigned partial sum from the sum stage
- ACC_W, 16, width of accumulator and result
- BEATS, 4, beats per result when `in_last` is not asserted; legal range 1..255
- CNT_W, 8, width of the beat counter and of `out_beats`

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  partial sum on `in_data` is valid
- in_ready  output  1  block accepts `in_data` this cycle
- in_data  input  IN_W  unsigned partial sum
- in_last  input  1  closes the current result early; qualified by the input handshake
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_W  accumulated result
- out_beats  output  CNT_W  number of beats folded into `out_data`
- out_ovf  output  1  accumulation exceeded 2^ACC_W-1 at least once for this result

Behaviour:
- Reset: `rst` sampled high at a clock edge clears the accumulator, the beat counter, the sticky overflow flag, `out_valid`, `out_data`, `out_beats` and `out_ovf` to 0.
  - Reset during an accumulation or while `out_valid`=1 discards all partial and pending data.
  - `in_ready`=1 in the first cycle after reset.
- Handshakes:
  - Input handshake = `in_valid && in_ready`.
  - Output handshake = `out_valid && out_ready`.
  - `in_ready = !out_valid || out_ready` (combinational from `out_ready` only).
- States:
  - ACCUM: `out_valid`=0; accepting beats.
  - HOLD: `out_valid`=1; result registered.
- ACCUM, input handshake that is not closing:
  - acc <= acc + zero-extended `in_data`.
  - cnt <= cnt + 1.
  - ovf <= ovf | carry.
- Closing beat: an input handshake with `in_last`=1, or with cnt == BEATS-1.
  - `out_data` <= acc + `in_data` (wrapped or saturated, see Optional Feature).
  - `out_beats` <= cnt + 1.
  - `out_ovf` <= ovf | carry.
  - acc, cnt and ovf clear; state goes to HOLD.
  - Latency from closing beat to `out_valid`=1 is 1 cycle.
- HOLD:
  - `out_data`, `out_beats` and `out_ovf` remain stable until the output handshake.
  - Output handshake with no input handshake: `out_valid` <= 0, state goes to ACCUM.
  - Output handshake with a simultaneous input handshake: the new beat starts the next result (acc <= `in_data`, cnt <= 1).
  - If that simultaneous beat is itself closing (BEATS=1 or `in_last`), `out_valid` stays 1 with the new result; no bubble.
- Beat counting:
  - `in_valid`=0 cycles are ignored and neither advance cnt nor alter acc.
  - `in_last` without `in_valid` is ignored.
- Arithmetic:
  - All arithmetic is unsigned.
  - Carry = bit ACC_W of the (ACC_W+1)-bit sum.
  - Without saturation the accumulator wraps modulo 2^ACC_W.
- Stall behaviour: while `out_valid`=1 and `out_ready`=0, `in_ready`=0 and no state changes.

Optional Feature:
- Macro `PSUM_ACC_SAT_EN`.
- When defined: on carry, the accumulator and `out_data` clamp to 2^ACC_W-1 and stay clamped for the remaining beats of that result. `out_ovf` is still set.
- When undefined: wrap modulo 2^ACC_W; `out_ovf` reports the wrap.
- The flag behaviour is identical in both builds; only the data value differs.

Test Plan:
- Defaults, `out_ready`=1, beats 6,7,0,5 on consecutive cycles, `in_last`=0 -> one cycle after the 4th beat: `out_data`=18, `out_beats`=4, `out_ovf`=0; `in_ready` remains 1 throughout.
- Beats 3,2 with `in_last`=1 on the 2nd -> `out_data`=5, `out_beats`=2. The next 4 beats of 1 -> `out_data`=4, `out_beats`=4.
- Hold `out_ready`=0 after a result of 18 for 5 cycles while `in_valid`=1 with data 7 -> `in_ready`=0 and `out_data` stable at 18. Raise `out_ready` -> 18 is consumed, and the 7 is accepted in the same cycle as the first beat of the next result.
- ACC_W=4, beats 7,7,7,1 -> without the macro: `out_data`=6, `out_ovf`=1. With `PSUM_ACC_SAT_EN`: `out_data`=15, `out_ovf`=1.
- BEATS=1, `out_ready`=1, continuous beats 1,2,3 -> `out_valid` stays high for 3 consecutive cycles presenting 1,2,3, each with `out_beats`=1.
- Assert `rst` for one cycle after 2 of 4 beats (data 5,5) -> `out_valid`=0. The following 4 beats of 2 -> `out_data`=8, not 18.

Source files
------------

// File: rtl/psum_accumulator.sv
// Folds a stream of IN_W-bit partial sums into one ACC_W-bit result per BEATS beats (or early in_last).
// Optional build macro PSUM_ACC_SAT_EN clamps the result at 2^ACC_W-1 instead of wrapping.
module psum_accumulator #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16,
  parameter int BEATS = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam logic ACCUM = 1'b0;
  localparam logic HOLD  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic             r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_ovf;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_close;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_next;

  assign out_valid = (r_state == HOLD);
  assign in_ready  = (r_state == ACCUM) || out_ready;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;
  assign out_ovf   = r_out_ovf;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_close  = in_last || (r_cnt == LAST_CNT);
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign w_carry  = w_sum[ACC_W];

`ifdef PSUM_ACC_SAT_EN
  // Once clamped, any further nonzero beat carries again, so the value stays pinned.
  assign w_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_next = w_sum[ACC_W-1:0];
`endif

  // acc/cnt/ovf are zero whenever a result is held, so a beat accepted alongside
  // the output handshake naturally starts the next result from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_in_hs) begin
      if (w_close) begin
        r_out_data  <= w_next;
        r_out_beats <= r_cnt + ONE_CNT;
        r_out_ovf   <= r_ovf | w_carry;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
        r_state     <= HOLD;
      end else begin
        r_acc <= w_next;
        r_cnt <= r_cnt + ONE_CNT;
        r_ovf <= r_ovf | w_carry;
        if (w_out_hs) begin
          r_state <= ACCUM;
        end
      end
    end else if (w_out_hs) begin
      r_state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: default, narrow (ACC_W=4) and single-beat (BEATS=1) instances.
module tb_psum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        inValid, inLast, outReady, inReady, outValid, outOvf;
  logic [2:0]  inData;
  logic [15:0] outData;
  logic [7:0]  outBeats;

  logic        inValidN, inLastN, outReadyN, inReadyN, outValidN, outOvfN;
  logic [2:0]  inDataN;
  logic [3:0]  outDataN;
  logic [7:0]  outBeatsN;

  logic        inValidS, inLastS, outReadyS, inReadyS, outValidS, outOvfS;
  logic [2:0]  inDataS;
  logic [15:0] outDataS;
  logic [7:0]  outBeatsS;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_last(inLast), .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_beats(outBeats), .out_ovf(outOvf)
  );

  psum_accumulator #(.ACC_W(4)) dutNarrow (
    .clk(clk), .rst(rst), .in_valid(inValidN), .in_ready(inReadyN), .in_data(inDataN),
    .in_last(inLastN), .out_valid(outValidN), .out_ready(outReadyN), .out_data(outDataN),
    .out_beats(outBeatsN), .out_ovf(outOvfN)
  );

  psum_accumulator #(.BEATS(1)) dutSingle (
    .clk(clk), .rst(rst), .in_valid(inValidS), .in_ready(inReadyS), .in_data(inDataS),
    .in_last(inLastS), .out_valid(outValidS), .out_ready(outReadyS), .out_data(outDataS),
    .out_beats(outBeatsS), .out_ovf(outOvfS)
  );

  typedef struct {
    bit        v;
    bit [2:0]  d;
    bit        l;
    bit        r;
    bit        p;
    bit        eir;
    bit [15:0] ed;
    bit [7:0]  eb;
    bit        eo;
  } stim_t;

  typedef struct {
    bit [15:0] ed;
    bit [7:0]  eb;
    bit        eo;
  } exp_t;

  stim_t stimQ[$];
  exp_t  expQ[$];
  int    nVec = 0;
  int    nErr = 0;

  task automatic add(input bit v, input bit [2:0] d, input bit l, input bit r, input bit p,
                     input bit eir, input bit [15:0] ed, input bit [7:0] eb, input bit eo);
    stim_t s;
    s.v = v; s.d = d; s.l = l; s.r = r; s.p = p; s.eir = eir; s.ed = ed; s.eb = eb; s.eo = eo;
    stimQ.push_back(s);
  endtask

  task automatic idleAll();
    inValid = 0;  inData = 0;  inLast = 0;  outReady = 1;
    inValidN = 0; inDataN = 0; inLastN = 0; outReadyN = 1;
    inValidS = 0; inDataS = 0; inLastS = 0; outReadyS = 1;
  endtask

  task automatic test_reset();
    idleAll();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
    nVec++; if (outData !== 16'd0) begin nErr++; $display("[TB] FAIL reset_data got %0d want 0", outData); end
    nVec++; if (outBeats !== 8'd0) begin nErr++; $display("[TB] FAIL reset_beats got %0d want 0", outBeats); end
    nVec++; if (outOvf !== 1'b0) begin nErr++; $display("[TB] FAIL reset_ovf got %b want 0", outOvf); end
    nVec++; if ((outValidN !== 1'b0) || (outValidS !== 1'b0)) begin
      nErr++; $display("[TB] FAIL reset_valid_others got %b/%b want 0/0", outValidN, outValidS);
    end
    @(negedge clk);
    rst = 0;
    #1;
    nVec++; if (inReady !== 1'b1) begin nErr++; $display("[TB] FAIL reset_in_ready got %b want 1", inReady); end
    // Reset while a result is being held must drop it.
    outReady = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid = 1; inData = 3'd1;
    end
    @(negedge clk);
    inValid = 0;
    #1;
    nVec++; if (outValid !== 1'b1 || outData !== 16'd4) begin
      nErr++; $display("[TB] FAIL hold_before_reset got valid=%b data=%0d want 1/4", outValid, outData);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    outReady = 1;
    #1;
    nVec++; if (outValid !== 1'b0 || outData !== 16'd0) begin
      nErr++; $display("[TB] FAIL reset_in_hold got valid=%b data=%0d want 0/0", outValid, outData);
    end
  endtask

  task automatic test_accumulate();
    stimQ.delete();
    add(1, 6, 0, 1, 0, 1, 0, 0, 0);
    add(1, 7, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 5, 0, 1, 1, 1, 18, 4, 0);
    add(1, 3, 0, 1, 0, 1, 0, 0, 0);
    add(1, 2, 1, 1, 1, 1, 5, 2, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 4, 4, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 7, 1, 1, 0, 1, 0, 0, 0);
    add(1, 2, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 3, 0, 1, 0, 1, 0, 0, 0);
    add(1, 4, 0, 1, 1, 1, 10, 4, 0);
    for (int c = 0; c < stimQ.size() + 10; c++) begin
      stim_t s;
      exp_t  e;
      if (c >= stimQ.size() && expQ.size() == 0) break;
      @(negedge clk);
      if (c < stimQ.size()) s = stimQ[c];
      else begin s = '{default: 0}; s.r = 1; s.eir = 1; end
      inValid = s.v; inData = s.d; inLast = s.l; outReady = s.r;
      if (s.p) expQ.push_back('{s.ed, s.eb, s.eo});
      #1;
      nVec++; if (inReady !== s.eir) begin nErr++; $display("[TB] FAIL acc_in_ready cyc %0d got %b want %b", c, inReady, s.eir); end
      if (outValid !== 1'b0) begin
        nVec++;
        if (expQ.size() == 0) begin
          nErr++; $display("[TB] FAIL acc_unexpected cyc %0d got data=%0d want no result", c, outData);
        end else begin
          e = expQ[0];
          if (outData !== e.ed || outBeats !== e.eb || outOvf !== e.eo) begin
            nErr++;
            $display("[TB] FAIL acc_result cyc %0d got %0d/%0d/%b want %0d/%0d/%b",
                     c, outData, outBeats, outOvf, e.ed, e.eb, e.eo);
          end
          if (outReady) void'(expQ.pop_front());
        end
      end
    end
    nVec++; if (expQ.size() != 0) begin nErr++; $display("[TB] FAIL acc_timeout got %0d pending want 0", expQ.size()); expQ.delete(); end
    idleAll();
  endtask

  task automatic test_stall();
    stimQ.delete();
    add(1, 6, 0, 1, 0, 1, 0, 0, 0);
    add(1, 7, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 5, 0, 0, 1, 1, 18, 4, 0);
    for (int i = 0; i < 5; i++) add(1, 7, 0, 0, 0, 0, 0, 0, 0);
    add(1, 7, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 10, 4, 0);
    for (int c = 0; c < stimQ.size() + 10; c++) begin
      stim_t s;
      exp_t  e;
      if (c >= stimQ.size() && expQ.size() == 0) break;
      @(negedge clk);
      if (c < stimQ.size()) s = stimQ[c];
      else begin s = '{default: 0}; s.r = 1; s.eir = 1; end
      inValid = s.v; inData = s.d; inLast = s.l; outReady = s.r;
      if (s.p) expQ.push_back('{s.ed, s.eb, s.eo});
      #1;
      nVec++; if (inReady !== s.eir) begin nErr++; $display("[TB] FAIL stall_in_ready cyc %0d got %b want %b", c, inReady, s.eir); end
      if (outValid !== 1'b0) begin
        nVec++;
        if (expQ.size() == 0) begin
          nErr++; $display("[TB] FAIL stall_unexpected cyc %0d got data=%0d want no result", c, outData);
        end else begin
          e = expQ[0];
          if (outData !== e.ed || outBeats !== e.eb || outOvf !== e.eo) begin
            nErr++;
            $display("[TB] FAIL stall_result cyc %0d got %0d/%0d/%b want %0d/%0d/%b",
                     c, outData, outBeats, outOvf, e.ed, e.eb, e.eo);
          end
          if (outReady) void'(expQ.pop_front());
        end
      end
    end
    nVec++; if (expQ.size() != 0) begin nErr++; $display("[TB] FAIL stall_timeout got %0d pending want 0", expQ.size()); expQ.delete(); end
    idleAll();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inValid = 1; inData = 3'd5;
    end
    @(negedge clk);
    inValid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("[TB] FAIL mid_reset_valid got %b want 0", outValid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid = 1; inData = 3'd2;
      if (i == 3) expQ.push_back('{16'd8, 8'd4, 1'b0});
    end
    @(negedge clk);
    inValid = 0;
    #1;
    nVec++;
    if (outValid !== 1'b1) begin
      nErr++; $display("[TB] FAIL mid_reset_missing got valid=%b want 1", outValid);
      expQ.delete();
    end else begin
      e = expQ.pop_front();
      if (outData !== e.ed || outBeats !== e.eb || outOvf !== e.eo) begin
        nErr++; $display("[TB] FAIL mid_reset_result got %0d/%0d/%b want %0d/%0d/%b",
                         outData, outBeats, outOvf, e.ed, e.eb, e.eo);
      end
    end
    idleAll();
  endtask

  task automatic test_overflow();
    exp_t e;
    bit [2:0] beats [4];
    beats[0] = 7; beats[1] = 7; beats[2] = 7; beats[3] = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValidN = 1; inDataN = beats[i];
`ifdef PSUM_ACC_SAT_EN
      if (i == 3) expQ.push_back('{16'd15, 8'd4, 1'b1});
`else
      if (i == 3) expQ.push_back('{16'd6, 8'd4, 1'b1});
`endif
    end
    @(negedge clk);
    inValidN = 0;
    #1;
    nVec++;
    if (outValidN !== 1'b1) begin
      nErr++; $display("[TB] FAIL ovf_missing got valid=%b want 1", outValidN);
      expQ.delete();
    end else begin
      e = expQ.pop_front();
      if ({12'd0, outDataN} !== e.ed || outBeatsN !== e.eb || outOvfN !== e.eo) begin
        nErr++; $display("[TB] FAIL ovf_result got %0d/%0d/%b want %0d/%0d/%b",
                         outDataN, outBeatsN, outOvfN, e.ed, e.eb, e.eo);
      end
    end
    idleAll();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      inValidS = (c < 3);
      inDataS  = (c < 3) ? 3'(c + 1) : 3'd0;
      if (c < 3) expQ.push_back('{16'(c + 1), 8'd1, 1'b0});
      #1;
      if (c >= 1) begin
        nVec++;
        if (outValidS !== (c <= 3)) begin
          nErr++; $display("[TB] FAIL b2b_valid cyc %0d got %b want %b", c, outValidS, (c <= 3));
        end
        if (outValidS === 1'b1 && expQ.size() != 0) begin
          e = expQ.pop_front();
          nVec++;
          if (outDataS !== e.ed || outBeatsS !== e.eb || outOvfS !== e.eo) begin
            nErr++; $display("[TB] FAIL b2b_result cyc %0d got %0d/%0d/%b want %0d/%0d/%b",
                             c, outDataS, outBeatsS, outOvfS, e.ed, e.eb, e.eo);
          end
        end
      end
    end
    nVec++; if (expQ.size() != 0) begin nErr++; $display("[TB] FAIL b2b_pending got %0d want 0", expQ.size()); expQ.delete(); end
    idleAll();
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_stall();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
